ex_loop: RTL
============

Name: ex_loop

Overview:
Parametrised successor to the PPWM instruction executor.
- Runs a small per-period program that sets the PWM compare value for one channel.
- Generalises the register file to NUM_REGS entries, with configurable immediate and PC widths.
- Adds signed relative jumps, saturating add, a decrement-and-branch loop instruction, an explicit HALT, and start-overrun detection.
- Sits between the instruction memory (addressed by pc_o) and the PWM comparator (fed by pwm_value_o).

Parameters:
COUNTER_WIDTH, 8, width of the global counter, registers and PWM value
PC_WIDTH, 4, program counter width; program length is 2^PC_WIDTH
NUM_REGS, 4, number of general registers; power of two, at least 2
IMM_WIDTH, 4, immediate field width; must be less than COUNTER_WIDTH
INSTR_WIDTH, 3+1+clog2(NUM_REGS)+IMM_WIDTH (10 with defaults), instruction width; derived, not overridable

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start_i  input  1  single-cycle pulse marking the start of a PWM period
global_counter_i  input  COUNTER_WIDTH  current global counter value
instr_i  input  INSTR_WIDTH  instruction at pc_o; combinational fetch, valid in the same cycle
pc_o  output  PC_WIDTH  program counter
pwm_value_o  output  COUNTER_WIDTH  registered PWM compare value
busy_o  output  1  high while in Exec
overrun_o  output  1  one-cycle pulse when start_i arrives during Exec

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset: state Idle, pc_o=0, pwm_value_o=0, every register 0, cmp flag 0, busy_o=0, overrun_o=0.
- Instruction fields, LSB first:
  - OP: bits [2:0]
  - T: bit [3]; 0 selects reg[RSEL], 1 selects PWM
  - RSEL: next clog2(NUM_REGS) bits
  - IMM: top IMM_WIDTH bits
  - OFS: bits [INSTR_WIDTH-1:3], two's-complement signed
- FSM states: Idle, Exec, Wait.
  - Idle, start_i -> Exec, with pc=0.
  - Wait, start_i -> Exec; pc is kept.
  - Exec executes one instruction per cycle.
- PC update in Exec: default pc+1.
  - Jump target is pc + sign-extended offset, modulo 2^PC_WIDTH.
  - If the instruction at pc=2^PC_WIDTH-1 does not redirect the PC: pc wraps to 0 and FSM goes to Idle.
  - A taken JUMP, BRANCH or DJNZ at the last address stays in Exec.
- Opcodes:
  - 0 CTRL, sub-code in OFS:
    - 0: NOP
    - 1: WAIT; pc+1, go to Wait
    - 2: HALT; pc=0, go to Idle
    - other values: NOP
  - 1 SET: target = zero-extended IMM.
  - 2 ADD: target = target + IMM, saturating at all-ones (no wrap).
  - 3 SHIFT: IMM[0]=1 shifts left by 1, 0 shifts right by 1; zero fill.
  - 4 JUMP: pc = pc + OFS; unconditional.
  - 5 CMP: flag = (global_counter_i < target), unsigned. The flag persists until the next CMP, across periods.
  - 6 BRANCH: if flag, pc = pc + OFS.
  - 7 DJNZ: reg[RSEL] = reg[RSEL] - 1.
    - Offset is IMM, sign-extended.
    - If the decremented value != 0, pc = pc + IMM_offset.
    - If reg[RSEL] is 0 before the decrement: no decrement, no branch, pc+1.
    - T is ignored.
- Timing:
  - All updates become visible the cycle after execution.
  - pwm_value_o is the register value itself, with no extra latency.
  - busy_o = (state == Exec).
- start_i handling:
  - start_i during Exec is ignored for control and pulses overrun_o on the following cycle.
  - start_i on the same cycle as the Exec->Idle transition is also an overrun; no restart occurs.
- Reset asserted mid-program: immediate return to reset values; any executing write is lost.
- Illegal encodings: none exist outside CTRL sub-codes; there are no X-propagating defaults.

Test Plan:
- SET PWM,5; HALT; then start_i -> pwm_value_o=5 two cycles after start_i; pc_o=0, busy_o=0 after HALT.
- Loop with reg0=3: SET R0,3; ADD PWM,2; DJNZ R0,-1; HALT -> pwm_value_o=6; reg0 ends at 0; the ADD executes 3 times.
- ADD PWM,15 repeated from 250 (COUNTER_WIDTH=8) -> pwm_value_o saturates at 255 and stays there.
- CMP PWM with counter=3, pwm=5 -> flag=1; BRANCH +2 skips one instruction. Repeat with counter=7 -> not taken.
- WAIT at pc=2: busy_o drops, pc_o=3 held. Next start_i -> execution resumes at 3, not 0.
- start_i pulsed at the 2nd Exec cycle -> overrun_o high exactly one cycle, program unaffected. Async rst mid-Exec -> all outputs 0 with no clock edge needed.

Source files
------------

// File: rtl/ex_loop.sv
// Per-period PWM program executor: fetches from instruction memory at pc_o and
// updates the channel compare value, a small register file and a compare flag.
module ex_loop #(
   parameter int unsigned COUNTER_WIDTH = 8,
   parameter int unsigned PC_WIDTH      = 4,
   parameter int unsigned NUM_REGS      = 4,
   parameter int unsigned IMM_WIDTH     = 4,
   localparam int unsigned RSEL_WIDTH   = $clog2(NUM_REGS),
   localparam int unsigned INSTR_WIDTH  = 4 + RSEL_WIDTH + IMM_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [COUNTER_WIDTH-1:0] global_counter_i,
   input  logic [INSTR_WIDTH-1:0]   instr_i,
   output logic [PC_WIDTH-1:0]      pc_o,
   output logic [COUNTER_WIDTH-1:0] pwm_value_o,
   output logic                     busy_o,
   output logic                     overrun_o
);

   localparam int unsigned OFS_WIDTH = INSTR_WIDTH - 3;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WAIT = 2'd2} state_t;

   localparam logic [2:0] OP_CTRL   = 3'd0;
   localparam logic [2:0] OP_SET    = 3'd1;
   localparam logic [2:0] OP_ADD    = 3'd2;
   localparam logic [2:0] OP_SHIFT  = 3'd3;
   localparam logic [2:0] OP_JUMP   = 3'd4;
   localparam logic [2:0] OP_CMP    = 3'd5;
   localparam logic [2:0] OP_BRANCH = 3'd6;
   localparam logic [2:0] OP_DJNZ   = 3'd7;

   localparam logic [OFS_WIDTH-1:0] SUB_WAIT = OFS_WIDTH'(1);
   localparam logic [OFS_WIDTH-1:0] SUB_HALT = OFS_WIDTH'(2);

   state_t                   state_q, state_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic                     overrun_q, overrun_d;
   logic [COUNTER_WIDTH-1:0] pwm_q, pwm_d;
   logic [COUNTER_WIDTH-1:0] regs_q [NUM_REGS];
   logic [COUNTER_WIDTH-1:0] regs_d [NUM_REGS];
   logic                     flag_q, flag_d;

   logic [2:0]               op;
   logic                     t_pwm;
   logic [RSEL_WIDTH-1:0]    rsel;
   logic [IMM_WIDTH-1:0]     imm;
   logic [OFS_WIDTH-1:0]     ofs;

   logic [COUNTER_WIDTH-1:0] sel_reg, target, imm_ext, add_res, shift_res, wr_val;
   logic [COUNTER_WIDTH:0]   add_full;
   logic [PC_WIDTH-1:0]      pc_inc, jump_tgt, djnz_tgt;
   logic                     djnz_live, djnz_take, wr_en;

   assign op    = instr_i[2:0];
   assign t_pwm = instr_i[3];
   assign rsel  = instr_i[4 +: RSEL_WIDTH];
   assign imm   = instr_i[INSTR_WIDTH-1 -: IMM_WIDTH];
   assign ofs   = instr_i[INSTR_WIDTH-1:3];

   // Operand selection and arithmetic shared by all opcodes
   assign sel_reg   = regs_q[rsel];
   assign target    = t_pwm ? pwm_q : sel_reg;
   assign imm_ext   = {{(COUNTER_WIDTH-IMM_WIDTH){1'b0}}, imm};
   assign add_full  = {1'b0, target} + {1'b0, imm_ext};
   assign add_res   = add_full[COUNTER_WIDTH] ? '1 : add_full[COUNTER_WIDTH-1:0];
   assign shift_res = imm[0] ? {target[COUNTER_WIDTH-2:0], 1'b0}
                             : {1'b0, target[COUNTER_WIDTH-1:1]};

   // Relative targets wrap modulo the program length
   assign pc_inc    = pc_q + PC_WIDTH'(1);
   assign jump_tgt  = pc_q + PC_WIDTH'($signed(ofs));
   assign djnz_tgt  = pc_q + PC_WIDTH'($signed(imm));
   assign djnz_live = (sel_reg != '0);
   assign djnz_take = djnz_live && (sel_reg != COUNTER_WIDTH'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         overrun_q <= overrun_d;
      end
   end

   // Next state and program counter
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      overrun_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_EXEC;
               pc_d    = '0;
            end
         end
         S_WAIT: begin
            if (start_i) state_d = S_EXEC;
         end
         S_EXEC: begin
            overrun_d = start_i;
            if (op == OP_CTRL && ofs == SUB_WAIT) begin
               state_d = S_WAIT;
               pc_d    = pc_inc;
            end else if (op == OP_CTRL && ofs == SUB_HALT) begin
               state_d = S_IDLE;
               pc_d    = '0;
            end else if (op == OP_JUMP || (op == OP_BRANCH && flag_q)) begin
               pc_d = jump_tgt;
            end else if (op == OP_DJNZ && djnz_take) begin
               pc_d = djnz_tgt;
            end else begin
               pc_d = pc_inc;
               if (pc_q == '1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath writes for the executing instruction
   always_comb begin
      pwm_d  = pwm_q;
      regs_d = regs_q;
      flag_d = flag_q;
      wr_en  = 1'b0;
      wr_val = '0;
      if (state_q == S_EXEC) begin
         case (op)
            OP_SET:   begin wr_en = 1'b1; wr_val = imm_ext;   end
            OP_ADD:   begin wr_en = 1'b1; wr_val = add_res;   end
            OP_SHIFT: begin wr_en = 1'b1; wr_val = shift_res; end
            OP_CMP:   flag_d = (global_counter_i < target);
            OP_DJNZ:  if (djnz_live) regs_d[rsel] = sel_reg - COUNTER_WIDTH'(1);
            default:  ;
         endcase
         if (wr_en) begin
            if (t_pwm) pwm_d = wr_val;
            else       regs_d[rsel] = wr_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_q  <= '0;
         flag_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         pwm_q  <= pwm_d;
         flag_q <= flag_d;
         regs_q <= regs_d;
      end
   end

   assign pc_o        = pc_q;
   assign pwm_value_o = pwm_q;
   assign busy_o      = (state_q == S_EXEC);
   assign overrun_o   = overrun_q;

endmodule
